// File: rtl/ogpu_buffer_arbiter_pkg.sv
// Shared widths, burst limit and command payload type for the OpenGPU buffer-RAM port-2 arbiter.
package ogpu_buffer_arb_pkg;

  localparam int ARB_NUM_REQ   = 4;
  localparam int ARB_ADDR_W    = 13;
  localparam int ARB_DATA_W    = 64;
  localparam int ARB_BE_W      = ARB_DATA_W / 8;
  localparam int ARB_MAX_BURST = 8;

  typedef struct packed {
    logic                  write;
    logic [ARB_ADDR_W-1:0] addr;
    logic [ARB_BE_W-1:0]   be;
    logic [ARB_DATA_W-1:0] wdata;
  } cmd_t;

  // Round-robin successor of a requester index, wrapping at n (n need not be a power of two).
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/ogpu_buffer_arbiter_if.sv
// Requester-side command/response bundle plus the RAM port-2 pins of the buffer arbiter.
interface ogpu_buffer_arbiter_if
  import ogpu_buffer_arb_pkg::*;
#(
  parameter int NUM_REQ = ARB_NUM_REQ,
  parameter int ADDR_W  = ARB_ADDR_W,
  parameter int DATA_W  = ARB_DATA_W,
  parameter int BE_W    = ARB_BE_W,
  parameter int GID_W   = $clog2(NUM_REQ)
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ-1:0]        req_lock;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ*BE_W-1:0]   req_be;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_rdata;
  logic [ADDR_W-1:0]         ram_address;
  logic [BE_W-1:0]           ram_byteenable;
  logic [DATA_W-1:0]         ram_writedata;
  logic                      ram_chipselect;
  logic                      ram_write;
  logic                      ram_clken;
  logic [DATA_W-1:0]         ram_readdata;
  logic [GID_W-1:0]          grant_id;

  // Arbiter side.
  modport slave (
    input  req_valid, req_write, req_lock, req_addr, req_wdata, req_be, ram_readdata,
    output req_ready, rsp_valid, rsp_rdata,
    output ram_address, ram_byteenable, ram_writedata, ram_chipselect, ram_write, ram_clken,
    output grant_id
  );

  // Requesters plus RAM model side.
  modport master (
    output req_valid, req_write, req_lock, req_addr, req_wdata, req_be, ram_readdata,
    input  req_ready, rsp_valid, rsp_rdata,
    input  ram_address, ram_byteenable, ram_writedata, ram_chipselect, ram_write, ram_clken,
    input  grant_id
  );

endinterface

// File: rtl/ogpu_buffer_arbiter_rr_picker.sv
// Combinational NUM_REQ-way round-robin picker: first set request at or after ptr_i, wrapping.
module ogpu_rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IW-1:0]      idx_o,
  output logic               any_o
);

  int          cand;
  logic [IW-1:0] cand_idx;

  always_comb begin
    grant_o  = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(ptr_i) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = IW'(cand);
      if (!any_o && req_i[cand_idx]) begin
        any_o             = 1'b1;
        grant_o[cand_idx] = 1'b1;
        idx_o             = cand_idx;
      end
    end
  end

endmodule

// File: rtl/ogpu_buffer_arbiter.sv
// Round-robin arbiter for port 2 of the OpenGPU buffer RAM; one command per cycle, 1-cycle read return.
// Optional lock-based burst holding is built when OGPU_BUFFER_ARB_BURST_EN is defined.
module ogpu_buffer_arbiter
  import ogpu_buffer_arb_pkg::*;
#(
  parameter int NUM_REQ   = ARB_NUM_REQ,
  parameter int ADDR_W    = ARB_ADDR_W,
  parameter int DATA_W    = ARB_DATA_W,
  parameter int BE_W      = ARB_BE_W,
  parameter int MAX_BURST = ARB_MAX_BURST
) (
  input  logic                   clk,
  input  logic                   reset_n,
  ogpu_buffer_arbiter_if.slave   bus
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]      grant_id_q, grant_id_d;
  logic [NUM_REQ-1:0] rsp_oh_q, rsp_oh_d;

  logic [NUM_REQ-1:0] pick_oh, win_oh;
  logic [IW-1:0]      pick_idx, win_idx;
  logic               pick_any;
  logic               hold_win;
  logic               accept;
  cmd_t               sel;

  ogpu_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_picker (
    .req_i   (bus.req_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (pick_oh),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

`ifdef OGPU_BUFFER_ARB_BURST_EN
  // hold_q: the last accepted beat asked to keep the grant and has burst budget left.
  logic          hold_q, hold_d;
  logic [CW-1:0] beat_q, beat_d;

  assign hold_win = hold_q && bus.req_valid[grant_id_q];

  always_comb begin
    beat_d = '0;
    hold_d = 1'b0;
    if (accept) begin
      beat_d = hold_win ? beat_q + 1'b1 : CW'(1);
      hold_d = bus.req_lock[win_idx] && (beat_d < CW'(MAX_BURST));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_q <= 1'b0;
      beat_q <= '0;
    end else begin
      hold_q <= hold_d;
      beat_q <= beat_d;
    end
  end
`else
  logic unused_ok;

  assign hold_win  = 1'b0;
  assign unused_ok = ^{bus.req_lock, CW'(MAX_BURST)};
`endif

  // A held burst owner is valid by construction, so pick_any also covers the hold case.
  assign accept  = reset_n && pick_any;
  assign win_oh  = hold_win ? (NUM_REQ'(1) << grant_id_q) : pick_oh;
  assign win_idx = hold_win ? grant_id_q : pick_idx;

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_oh[i]) begin
        sel.write = bus.req_write[i];
        sel.addr  = bus.req_addr[i*ADDR_W +: ADDR_W];
        sel.be    = bus.req_be[i*BE_W +: BE_W];
        sel.wdata = bus.req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // RAM port-2 drive: strobes only in an accept cycle, so the address register stalls otherwise.
  assign bus.req_ready      = accept ? win_oh : '0;
  assign bus.ram_chipselect = accept;
  assign bus.ram_clken      = accept;
  assign bus.ram_write      = accept && sel.write;
  assign bus.ram_address    = accept ? sel.addr  : '0;
  assign bus.ram_byteenable = accept ? sel.be    : '0;
  assign bus.ram_writedata  = accept ? sel.wdata : '0;

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    rsp_oh_d   = '0;
    if (accept) begin
      rr_ptr_d   = IW'(rr_next(int'(win_idx), NUM_REQ));
      grant_id_d = win_idx;
      rsp_oh_d   = sel.write ? '0 : win_oh;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      rsp_oh_q   <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      rsp_oh_q   <= rsp_oh_d;
    end
  end

  // Response stage: RAM q is unregistered, so read data is forwarded straight to the owner.
  assign bus.rsp_valid = rsp_oh_q;
  assign bus.rsp_rdata = (|rsp_oh_q) ? bus.ram_readdata : '0;
  assign bus.grant_id  = grant_id_q;

endmodule

// File: tb/tb_ogpu_buffer_arbiter.sv
// Scoreboard bench for ogpu_buffer_arbiter with a behavioural port-2 RAM; honours OGPU_BUFFER_ARB_BURST_EN.
module tb_ogpu_buffer_arbiter;
  import ogpu_buffer_arb_pkg::*;

  localparam int NR = 4;
  localparam int AW = 13;
  localparam int DW = 64;
  localparam int BW = 8;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  ogpu_buffer_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .BE_W(BW)) bus();

  ogpu_buffer_arbiter #(
    .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .BE_W(BW), .MAX_BURST(8)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural RAM: registered address (stalled by clken), unregistered q, byte-enabled write.
  logic [DW-1:0] mem     [0:8191];
  logic          wr_flag [0:8191];
  logic [AW-1:0] raddr_q;
  logic [DW-1:0] wr_tmp;

  function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
    return {16'hC0DE, 3'b000, a, ~{19'h0, a}};
  endfunction

  always @(posedge clk) begin
    if (bus.ram_clken && bus.ram_chipselect) begin
      if (bus.ram_write) begin
        wr_tmp = (wr_flag[bus.ram_address] === 1'b1) ? mem[bus.ram_address] : init_word(bus.ram_address);
        for (int b = 0; b < BW; b++)
          if (bus.ram_byteenable[b]) wr_tmp[8*b +: 8] = bus.ram_writedata[8*b +: 8];
        mem[bus.ram_address]     <= wr_tmp;
        wr_flag[bus.ram_address] <= 1'b1;
      end
      raddr_q <= bus.ram_address;
    end
  end

  assign bus.ram_readdata = (wr_flag[raddr_q] === 1'b1) ? mem[raddr_q] : init_word(raddr_q);

  typedef struct {
    int            due;
    int            id;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sbq[$];
  bit   mon_en = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      while (sbq.size() > 0 && sbq[0].due < cyc) begin
        exp_t m;
        m = sbq.pop_front();
        total++;
        bad++;
        $display("FAIL rsp_missed: id=%0d due=%0d not returned, now cycle %0d", m.id, m.due, cyc);
      end
      if (sbq.size() > 0 && sbq[0].due == cyc) begin
        exp_t e;
        e = sbq.pop_front();
        total++;
        if (bus.rsp_valid !== NR'(1 << e.id) || bus.rsp_rdata !== e.data) begin
          bad++;
          $display("FAIL rsp_data: got valid=%b data=%h, want valid=%b data=%h",
                   bus.rsp_valid, bus.rsp_rdata, NR'(1 << e.id), e.data);
        end
      end else begin
        total++;
        if (bus.rsp_valid !== '0) begin
          bad++;
          $display("FAIL rsp_unexpected: got valid=%b, want 0000", bus.rsp_valid);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic w, input logic lk,
                         input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] be);
    bus.req_valid[i]            = v;
    bus.req_write[i]            = w;
    bus.req_lock[i]             = lk;
    bus.req_addr[i*AW +: AW]    = a;
    bus.req_wdata[i*DW +: DW]   = d;
    bus.req_be[i*BW +: BW]      = be;
  endtask

  task automatic idle_all();
    for (int i = 0; i < NR; i++) set_req(i, 1'b0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic test_reset();
    logic [AW+BW+DW+NR*2+5+DW-1:0] outs;
    outs = {bus.req_ready, bus.rsp_valid, bus.ram_chipselect, bus.ram_clken, bus.ram_write,
            bus.ram_address, bus.ram_byteenable, bus.ram_writedata, bus.grant_id, bus.rsp_rdata};
    total++;
    if (outs !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got %h, want all zero", outs);
    end
    reset_n = 1'b1;
    mon_en  = 1'b1;
    tick();
    @(negedge clk);
    total++;
    if (bus.ram_clken !== 1'b0 || bus.ram_chipselect !== 1'b0 || bus.req_ready !== '0) begin
      bad++;
      $display("FAIL idle_strobes: got clken=%b cs=%b ready=%b, want 0 0 0000",
               bus.ram_clken, bus.ram_chipselect, bus.req_ready);
    end
    tick();
  endtask

  task automatic test_round_robin();
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, 1'b0, 1'b0, AW'(16 + i), '0, '0);
    for (int b = 0; b < 8; b++) begin
      int w;
      w = b % NR;
      @(negedge clk);
      total++;
      if (bus.req_ready !== NR'(1 << w) || bus.ram_address !== AW'(16 + w) ||
          bus.ram_write !== 1'b0 || bus.ram_clken !== 1'b1 || bus.ram_chipselect !== 1'b1) begin
        bad++;
        $display("FAIL rr_grant: got ready=%b addr=%h wr=%b clken=%b, want ready=%b addr=%h wr=0 clken=1",
                 bus.req_ready, bus.ram_address, bus.ram_write, bus.ram_clken, NR'(1 << w), AW'(16 + w));
      end
      sbq.push_back('{due: cyc + 1, id: w, data: init_word(AW'(16 + w))});
      tick();
      total++;
      if (bus.grant_id !== 2'(w)) begin
        bad++;
        $display("FAIL rr_grant_id: got %0d, want %0d", bus.grant_id, w);
      end
    end
    idle_all();
    tick();
    tick();
  endtask

  task automatic test_write_read();
    logic [DW-1:0] old_w;
    old_w = init_word(13'h1FFF);
    set_req(2, 1'b1, 1'b1, 1'b0, 13'h1FFF, 64'hDEAD_BEEF_0123_4567, 8'h0F);
    @(negedge clk);
    total++;
    if (bus.req_ready !== 4'b0100 || bus.ram_write !== 1'b1 || bus.ram_byteenable !== 8'h0F ||
        bus.ram_address !== 13'h1FFF || bus.ram_writedata !== 64'hDEAD_BEEF_0123_4567) begin
      bad++;
      $display("FAIL wr_drive: got ready=%b wr=%b be=%h addr=%h wdata=%h, want 0100 1 0f 1fff deadbeef01234567",
               bus.req_ready, bus.ram_write, bus.ram_byteenable, bus.ram_address, bus.ram_writedata);
    end
    tick();
    set_req(2, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    set_req(1, 1'b1, 1'b0, 1'b0, 13'h1FFF, '0, '0);
    @(negedge clk);
    total++;
    if (bus.req_ready !== 4'b0010 || bus.ram_write !== 1'b0) begin
      bad++;
      $display("FAIL rd_after_wr_grant: got ready=%b wr=%b, want 0010 0", bus.req_ready, bus.ram_write);
    end
    sbq.push_back('{due: cyc + 1, id: 1, data: {old_w[63:32], 32'h0123_4567}});
    tick();
    idle_all();
    tick();
    tick();
  endtask

  task automatic test_burst();
    int n0, n1, nb;
    n0 = 0;
    n1 = 0;
`ifdef OGPU_BUFFER_ARB_BURST_EN
    nb = 13;
`else
    nb = 23;
`endif
    set_req(0, 1'b1, 1'b0, 1'b1, AW'(12'h100), '0, '0);
    set_req(1, 1'b1, 1'b0, 1'b0, AW'(12'h200), '0, '0);
    for (int b = 0; b < nb; b++) begin
      int w;
      logic [AW-1:0] a;
`ifdef OGPU_BUFFER_ARB_BURST_EN
      w = (b == 8) ? 1 : 0;
`else
      w = b % 2;
`endif
      a = (w == 0) ? AW'(12'h100 + n0) : AW'(12'h200 + n1);
      @(negedge clk);
      total++;
      if (bus.req_ready !== NR'(1 << w) || bus.ram_address !== a) begin
        bad++;
        $display("FAIL burst_beat%0d: got ready=%b addr=%h, want ready=%b addr=%h",
                 b, bus.req_ready, bus.ram_address, NR'(1 << w), a);
      end
      sbq.push_back('{due: cyc + 1, id: w, data: init_word(a)});
      tick();
      if (w == 0) n0++;
      else n1++;
      set_req(0, n0 < 12, 1'b0, 1'b1, AW'(12'h100 + n0), '0, '0);
      set_req(1, n0 < 12, 1'b0, 1'b0, AW'(12'h200 + n1), '0, '0);
    end
    idle_all();
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    set_req(2, 1'b1, 1'b0, 1'b0, AW'(12'h030), '0, '0);
    @(negedge clk);
    total++;
    if (bus.req_ready !== 4'b0100) begin
      bad++;
      $display("FAIL pre_reset_grant: got ready=%b, want 0100", bus.req_ready);
    end
    tick();
    idle_all();
    set_req(3, 1'b1, 1'b1, 1'b0, AW'(12'h031), 64'h1, 8'hFF);
    reset_n = 1'b0;
    #1;
    total++;
    if (bus.rsp_valid !== '0 || bus.ram_write !== 1'b0 || bus.ram_chipselect !== 1'b0 || bus.req_ready !== '0) begin
      bad++;
      $display("FAIL async_reset: got rsp_valid=%b wr=%b cs=%b ready=%b, want all 0",
               bus.rsp_valid, bus.ram_write, bus.ram_chipselect, bus.req_ready);
    end
    tick();
    reset_n = 1'b1;
    idle_all();
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, 1'b0, 1'b0, AW'(12'h040 + i), '0, '0);
    @(negedge clk);
    total++;
    if (bus.req_ready !== 4'b0001 || bus.grant_id !== 2'd0) begin
      bad++;
      $display("FAIL post_reset_first: got ready=%b gid=%0d, want 0001 0", bus.req_ready, bus.grant_id);
    end
    sbq.push_back('{due: cyc + 1, id: 0, data: init_word(AW'(12'h040))});
    tick();
    idle_all();
    tick();
    tick();
  endtask

  initial begin
    reset_n = 1'b0;
    idle_all();
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_round_robin();
    test_write_read();
    test_burst();
    test_reset_mid();
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: got %0d pending responses, want 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
